// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ            : number of requesters
//   PTR_W            : width of the round-robin pointer / owner index
//   HOLD_MAX_DEFAULT : default maximum grant hold time in cycles
//   state_t          : arbiter FSM state encoding
package rr_arbiter8_pkg;

    localparam int unsigned N_REQ            = 8;
    localparam int unsigned PTR_W            = 3;
    localparam int unsigned HOLD_MAX_DEFAULT = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request bit searching upward
// from ptr, wrapping 7 -> 0.
//   req      [7:0] in  : request lines
//   ptr      [2:0] in  : highest-priority position for this search
//   pick     [7:0] out : one-hot winner, 0 when req == 0
//   pick_idx [2:0] out : index of the winner (meaningless when req == 0)
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] pick_idx
);

    logic [N_REQ-1:0] rot;
    logic [PTR_W-1:0] first;
    logic             found;

    always_comb begin
        // Rotate so that bit ptr lands at position 0: rot[j] = req[(j+ptr) mod 8].
        rot   = N_REQ'({req, req} >> ptr);
        found = |rot;
        first = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                first = PTR_W'(i - 1);
            end
        end
        // Un-rotate; 3-bit addition wraps modulo 8.
        pick_idx = first + ptr;
        pick     = found ? (N_REQ'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold time. Produces a registered
// one-hot (or zero) grant suitable for driving an 8-to-3 priority encoder.
//   HOLD_MAX       : maximum cycles a grant may be held (1..255)
//   CNT_W          : hold-counter width, 2**CNT_W > HOLD_MAX
//   clk      in    : clock, rising edge
//   rst      in    : asynchronous active-high reset
//   req  [7:0] in  : request lines
//   done     in    : owner releases grant (sampled only while granted)
//   grant[7:0] out : registered one-hot grant or 0
//   valid    out   : grant is non-zero
//   timeout  out   : one-cycle pulse after a forced (hold-limit) release
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int unsigned CNT_W    = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic             timeout
);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic             rel_done, rel_drop, rel_hold;

    rr_pick8 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rel_done  = 1'b0;
        rel_drop  = 1'b0;
        rel_hold  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    valid_d = 1'b1;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                rel_done = done;
                rel_drop = ~req[owner_q];
                rel_hold = (cnt_q == CNT_W'(HOLD_MAX - 1));
                if (rel_done || rel_drop || rel_hold) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = owner_q + PTR_W'(1);
                    state_d   = IDLE;
                    // Only a purely hold-limit release is reported as a timeout.
                    timeout_d = rel_hold & ~rel_done & ~rel_drop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign grant   = grant_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (HOLD_MAX = 4).
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       valid;
    logic       timeout;

    int tests;
    int fails;

    rr_arbiter8 #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eg, input logic ev, input logic et);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {grant, valid, timeout};
        exp = {eg, ev, et};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: grant/valid/timeout got %h/%b/%b want %h/%b/%b",
                   tag, grant, valid, timeout, eg, ev, et);
        end
    endtask

    initial begin
        logic [7:0] e;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 8'h00;
        done  = 1'b0;

        // Reset
        step(); step();
        chk("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("idle_after_reset", 8'h00, 1'b0, 1'b0);

        // Single request, release by done; ptr then 5 (bit 5 beats bit 4)
        req = 8'h10;
        step(); chk("single_grant", 8'h10, 1'b1, 1'b0);
        done = 1'b1;
        step(); chk("single_release", 8'h00, 1'b0, 1'b0);
        done = 1'b0; req = 8'h30;
        step(); chk("ptr5_priority", 8'h20, 1'b1, 1'b0);
        done = 1'b1;
        step(); chk("ptr5_release", 8'h00, 1'b0, 1'b0);
        done = 1'b0; req = 8'h00;
        step(); chk("idle1", 8'h00, 1'b0, 1'b0);

        // Wrap and skip from ptr=6
        req = 8'h05;
        step(); chk("wrap_grant", 8'h01, 1'b1, 1'b0);
        done = 1'b1;
        step(); chk("wrap_release", 8'h00, 1'b0, 1'b0);
        done = 1'b0;
        step(); chk("skip_grant", 8'h04, 1'b1, 1'b0);
        done = 1'b1;
        step(); chk("skip_release", 8'h00, 1'b0, 1'b0);
        done = 1'b0; req = 8'h00;
        step(); chk("idle2", 8'h00, 1'b0, 1'b0);

        // Timeout with HOLD_MAX=4 (ptr=3)
        req = 8'h02;
        step(); chk("to_hold1", 8'h02, 1'b1, 1'b0);
        step(); chk("to_hold2", 8'h02, 1'b1, 1'b0);
        step(); chk("to_hold3", 8'h02, 1'b1, 1'b0);
        step(); chk("to_hold4", 8'h02, 1'b1, 1'b0);
        step(); chk("to_pulse", 8'h00, 1'b0, 1'b1);
        step(); chk("to_regrant", 8'h02, 1'b1, 1'b0);
        step(); chk("tod_hold2", 8'h02, 1'b1, 1'b0);
        step(); chk("tod_hold3", 8'h02, 1'b1, 1'b0);
        step(); chk("tod_hold4", 8'h02, 1'b1, 1'b0);
        done = 1'b1;
        step(); chk("tod_no_pulse", 8'h00, 1'b0, 1'b0);
        done = 1'b0; req = 8'h00;
        step(); chk("idle3", 8'h00, 1'b0, 1'b0);

        // Request drop by owner 3 (ptr=2)
        req = 8'h88;
        step(); chk("drop_grant", 8'h08, 1'b1, 1'b0);
        req = 8'h80;
        step(); chk("drop_release", 8'h00, 1'b0, 1'b0);
        step(); chk("drop_next", 8'h80, 1'b1, 1'b0);
        done = 1'b1;
        step(); chk("drop_next_rel", 8'h00, 1'b0, 1'b0);
        done = 1'b0; req = 8'h00;

        // Asynchronous reset mid-grant (ptr=0)
        req = 8'h40;
        step(); chk("async_pre", 8'h40, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1 chk("async_rst", 8'h00, 1'b0, 1'b0);
        step(); chk("async_held", 8'h00, 1'b0, 1'b0);
        rst = 1'b0; req = 8'hFF;

        // Round-robin under continuous requests
        step(); chk("rr_grant0", 8'h01, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            step(); chk($sformatf("rr_gap%0d", k), 8'h00, 1'b0, 1'b0);
            done = 1'b0;
            e = 8'(1 << (k % 8));
            step(); chk($sformatf("rr_grant%0d", k), e, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
